lcd_write_controller: RTL and testbench
=======================================

// Module: lcd_write_controller
// PURPOSE
//  HD44780-style 8-bit LCD transmitter. Runs the power-up init sequence, then accepts one byte per
//  valid/ready handshake and generates RS/EN/RW/DATA timing for it. Its LCD_* outputs drive the
//  LCD_*In inputs of the output wrapper, which passes them to the board pins.
// PARAMETERS
//  PWRUP_CYC      750000  idle cycles after reset before the first init write (15 ms at 50 MHz)
//  SETUP_CYC      4       cycles RS/DATA are stable before EN rises
//  EN_PULSE_CYC   25      cycles EN is held high
//  HOLD_CYC       4       cycles RS/DATA are held after EN falls
//  CMD_WAIT_CYC   2000    post-write wait for normal commands and data (40 us)
//  CLEAR_WAIT_CYC 82000   post-write wait for commands 0x01 and 0x02 (1.64 ms)
// PORTS
//  clk        in   1  system clock; one clock domain
//  reset      in   1  synchronous, active-high reset
//  req_valid  in   1  write request present
//  req_rs     in   1  0 = command, 1 = character data
//  req_data   in   8  byte to write
//  req_ready  out  1  block can accept a request (high only in IDLE)
//  init_done  out  1  init sequence has completed; sticky until reset
//  LCD_ON     out  1  panel power/backlight enable
//  LCD_RS     out  1  register select
//  LCD_EN     out  1  enable strobe
//  LCD_RW     out  1  read/write select; tied to 0 (write only)
//  LCD_DATA   out  8  data bus
// BEHAVIOUR
//  - All outputs are registered. On reset: LCD_ON=0, LCD_RS=0, LCD_EN=0, LCD_RW=0, LCD_DATA=0,
//    req_ready=0, init_done=0, state=PWRUP, timer=0.
//  - LCD_ON goes to 1 on the first clock edge after reset deasserts.
//  - States: PWRUP -> INIT_LOAD -> SETUP -> PULSE -> HOLD -> WAIT -> (INIT_LOAD | IDLE).
//    * PWRUP: count PWRUP_CYC cycles, then go to INIT_LOAD.
//    * INIT_LOAD: load ROM[idx] with RS=0, then go to SETUP. ROM contents:
//      0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 (6 entries).
//    * SETUP: RS and DATA are driven, EN=0, for SETUP_CYC cycles.
//    * PULSE: EN=1 for exactly EN_PULSE_CYC cycles.
//    * HOLD: EN=0 and RS/DATA unchanged, for HOLD_CYC cycles.
//    * WAIT: lasts CLEAR_WAIT_CYC if RS=0 and the byte is 0x01 or 0x02; otherwise CMD_WAIT_CYC.
//      RS/DATA keep their last value.
//    * Leaving WAIT: go to INIT_LOAD if init entries remain. After the 6th entry, set init_done
//      and go to IDLE.
//    * IDLE: req_ready=1. When req_valid && req_ready at edge t, capture req_rs/req_data,
//      drop req_ready, and drive LCD_RS/LCD_DATA from edge t+1 (state SETUP).
//  - Per-write latency:
//    * EN rises SETUP_CYC cycles after RS/DATA become valid.
//    * req_ready returns 1 exactly SETUP+EN_PULSE+HOLD+wait cycles after RS/DATA became valid.
//  - Back-to-back requests are allowed: a request held valid is accepted on the first IDLE cycle.
//  - Requests during init or mid-write are not accepted (req_ready=0); the requester must hold
//    them. req_* inputs are ignored outside the accept edge.
//  - The phase timer is a single down-counter, TW = $clog2(max of all CYC params + 1) bits. It is
//    loaded with N-1 on phase entry; the phase ends when it reaches 0. Every CYC parameter must
//    be >= 1; a value of 1 gives a 1-cycle phase.
//  - Reset mid-operation (including reset while EN=1) takes priority over everything:
//    * outputs return to reset values on that edge, so EN falls with no glitch;
//    * init restarts from PWRUP and init_done clears.
//  - LCD_RW is constant 0; the block never reads the busy flag.
// STRUCTURE
//  - Package lcd_pkg holds: the state enum; the init ROM as a localparam array with length 6;
//    command constants CMD_FUNC_SET=0x38, CMD_DISP_ON=0x0C, CMD_CLEAR=0x01, CMD_HOME=0x02,
//    CMD_ENTRY=0x06; and the is_long_cmd(rs, byte) function.
//  - One sub-module, lcd_phase_timer (load value, load strobe, zero flag), holds the down-counter.
//  - The FSM and output registers stay in this module.
// TESTING (params PWRUP=10, SETUP=2, EN_PULSE=4, HOLD=2, CMD_WAIT=8, CLEAR_WAIT=20)
//  1. Reset release -> LCD_ON=1 next cycle. 6 EN pulses, each exactly 4 cycles high, with DATA
//     38,38,38,0C,01,06 and RS=0. The gap after 0x01 is 20 wait cycles. Then init_done=1 and
//     req_ready=1.
//  2. After init, write rs=1 data=0x41 -> RS=1 and DATA=0x41 next cycle; EN high at +2 for
//     4 cycles; req_ready back at +16 (2+4+2+8).
//  3. Write rs=0 data=0x01 -> 20-cycle wait, req_ready at +28. Same byte with rs=1 -> 8-cycle
//     wait only.
//  4. req_valid held high through init and two writes -> each request accepted exactly once, on
//     the first IDLE cycle; no requests lost or duplicated.
//  5. Assert reset during PULSE of the 2nd user write -> EN=0 on the next edge, init_done=0,
//     full init sequence replays.
//  6. Checker on every cycle: LCD_RW==0; RS/DATA stable whenever EN=1 and for HOLD cycles after
//     EN falls; EN high widths equal EN_PULSE_CYC.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types, constants and helpers for the HD44780-style write controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP     = 3'd0,
    ST_INIT_LOAD = 3'd1,
    ST_SETUP     = 3'd2,
    ST_PULSE     = 3'd3,
    ST_HOLD      = 3'd4,
    ST_WAIT      = 3'd5,
    ST_IDLE      = 3'd6
  } lcd_state_e;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;

  localparam int INIT_LEN = 6;

  // Power-up command sequence, written in order with RS=0.
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
    CMD_FUNC_SET, CMD_FUNC_SET, CMD_FUNC_SET, CMD_DISP_ON, CMD_CLEAR, CMD_ENTRY
  };

  // Clear and home need the long post-write wait; everything else uses the short one.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && ((b == CMD_CLEAR) || (b == CMD_HOME));
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Single down-counter shared by all phases: load N-1 on entry, phase ends at zero.
module lcd_phase_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          zero
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Next count: a load wins, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_write_controller.sv
// HD44780-style 8-bit LCD write controller: power-up init, then one byte per
// handshake. Handshake: a request transfers on an edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, and the requester
// holds req_* stable until that edge.
module lcd_write_controller
  import lcd_pkg::*;
#(
  parameter int unsigned PWRUP_CYC      = 750000,
  parameter int unsigned SETUP_CYC      = 4,
  parameter int unsigned EN_PULSE_CYC   = 25,
  parameter int unsigned HOLD_CYC       = 4,
  parameter int unsigned CMD_WAIT_CYC   = 2000,
  parameter int unsigned CLEAR_WAIT_CYC = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       LCD_ON,
  output logic       LCD_RS,
  output logic       LCD_EN,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  localparam int unsigned MAX_CYC = max2(max2(max2(PWRUP_CYC, SETUP_CYC),
                                              max2(EN_PULSE_CYC, HOLD_CYC)),
                                         max2(CMD_WAIT_CYC, CLEAR_WAIT_CYC));
  localparam int TW = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] LD_PWRUP = TW'(PWRUP_CYC - 1);
  localparam logic [TW-1:0] LD_SETUP = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] LD_PULSE = TW'(EN_PULSE_CYC - 1);
  localparam logic [TW-1:0] LD_HOLD  = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] LD_CMD   = TW'(CMD_WAIT_CYC - 1);
  localparam logic [TW-1:0] LD_CLEAR = TW'(CLEAR_WAIT_CYC - 1);
  localparam logic [2:0]    IDX_LAST = 3'(INIT_LEN - 1);

  lcd_state_e    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic          on_q, on_d;
  logic          rs_q, rs_d;
  logic          en_q, en_d;
  logic [7:0]    data_q, data_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;

  lcd_phase_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Next state, next outputs and timer load for each phase.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    on_d     = on_q;
    rs_d     = rs_q;
    en_d     = en_q;
    data_d   = data_q;
    ready_d  = ready_q;
    done_d   = done_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_PWRUP: begin
        // First cycle out of reset: power the panel and start the power-up delay.
        if (!on_q) begin
          on_d     = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = LD_PWRUP;
        end else if (tmr_zero) begin
          state_d = ST_INIT_LOAD;
        end
      end
      ST_INIT_LOAD: begin
        rs_d     = 1'b0;
        data_d   = INIT_ROM[idx_q];
        tmr_load = 1'b1;
        tmr_val  = LD_SETUP;
        state_d  = ST_SETUP;
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          en_d     = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = LD_PULSE;
          state_d  = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (tmr_zero) begin
          en_d     = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = LD_HOLD;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = is_long_cmd(rs_q, data_q) ? LD_CLEAR : LD_CMD;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tmr_zero) begin
          if (done_q || (idx_q == IDX_LAST)) begin
            done_d  = 1'b1;
            ready_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_INIT_LOAD;
          end
        end
      end
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          rs_d     = req_rs;
          data_d   = req_data;
          ready_d  = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = LD_SETUP;
          state_d  = ST_SETUP;
        end
      end
      default: state_d = ST_PWRUP;
    endcase
  end

  // State and output registers; reset wins over every phase, so EN drops cleanly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_PWRUP;
      idx_q   <= 3'd0;
      on_q    <= 1'b0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      on_q    <= on_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign req_ready = ready_q;
  assign init_done = done_q;
  assign LCD_ON    = on_q;
  assign LCD_RS    = rs_q;
  assign LCD_EN    = en_q;
  assign LCD_RW    = 1'b0;
  assign LCD_DATA  = data_q;

endmodule

// File: tb/tb_lcd_write_controller.sv
// Bench for lcd_write_controller with shortened timing parameters.
module tb_lcd_write_controller;

  localparam int PWRUP  = 10;
  localparam int SETUP  = 2;
  localparam int PULSE  = 4;
  localparam int HOLD   = 2;
  localparam int CMDW   = 8;
  localparam int CLEARW = 20;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_rs;
  logic [7:0] req_data;
  logic       req_ready;
  logic       init_done;
  logic       LCD_ON;
  logic       LCD_RS;
  logic       LCD_EN;
  logic       LCD_RW;
  logic [7:0] LCD_DATA;

  int checks   = 0;
  int failures = 0;

  logic [8:0] exp_q[$];
  logic [7:0] tb_rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         lat;
  } vec_t;

  vec_t vecs [9];

  lcd_write_controller #(
    .PWRUP_CYC      (PWRUP),
    .SETUP_CYC      (SETUP),
    .EN_PULSE_CYC   (PULSE),
    .HOLD_CYC       (HOLD),
    .CMD_WAIT_CYC   (CMDW),
    .CLEAR_WAIT_CYC (CLEARW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .req_ready (req_ready),
    .init_done (init_done),
    .LCD_ON    (LCD_ON),
    .LCD_RS    (LCD_RS),
    .LCD_EN    (LCD_EN),
    .LCD_RW    (LCD_RW),
    .LCD_DATA  (LCD_DATA)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_init();
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, tb_rom[i]});
  endtask

  // Bus monitor: scoreboard pop on each EN rise, width and stability checks.
  logic       prev_en;
  logic       prev_rs;
  logic [7:0] prev_data;
  int         width;
  int         hold_cnt;
  logic [8:0] exp_item;

  always @(negedge clk) begin
    if (reset) begin
      prev_en  = 1'b0;
      width    = 0;
      hold_cnt = 0;
    end else begin
      check("rw_zero", 32'(LCD_RW), 32'd0);
      if (LCD_EN && !prev_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_item = exp_q.pop_front();
          check("write_byte", 32'({LCD_RS, LCD_DATA}), 32'(exp_item));
        end
        width = 1;
      end else if (LCD_EN) begin
        width++;
        check("stable_en", 32'({LCD_RS, LCD_DATA}), 32'({prev_rs, prev_data}));
      end else if (prev_en) begin
        check("en_width", 32'(width), 32'(PULSE));
        hold_cnt = HOLD;
      end
      if (!LCD_EN && hold_cnt > 0) begin
        check("stable_hold", 32'({LCD_RS, LCD_DATA}), 32'({prev_rs, prev_data}));
        hold_cnt--;
      end
      prev_en   = LCD_EN;
      prev_rs   = LCD_RS;
      prev_data = LCD_DATA;
    end
  end

  // Called on the negedge right after reset is released.
  task automatic run_init_check();
    int rise [6];
    int k;
    int cyc;
    logic pen;
    @(negedge clk);
    check("lcd_on_after_reset", 32'(LCD_ON), 32'd1);
    check("init_busy_ready", 32'(req_ready), 32'd0);
    k = 0;
    cyc = 1;
    pen = 1'b0;
    while (k < 6 && cyc < 1000) begin
      if (LCD_EN && !pen) begin
        rise[k] = cyc;
        k++;
      end
      pen = LCD_EN;
      @(negedge clk);
      cyc++;
    end
    check("init_pulse_count", 32'(k), 32'd6);
    if (k == 6) begin
      for (int j = 1; j < 6; j++)
        check("init_gap", 32'(rise[j] - rise[j-1]),
              32'(PULSE + HOLD + ((j == 5) ? CLEARW : CMDW) + 1 + SETUP));
      while (!init_done && cyc < 2000) begin
        @(negedge clk);
        cyc++;
      end
      check("init_done_time", 32'(cyc - rise[5]), 32'(PULSE + HOLD + CMDW));
      check("ready_after_init", 32'(req_ready), 32'd1);
    end
  endtask

  // Driver: one write through the handshake, with latency checks.
  task automatic do_write(input logic rs, input logic [7:0] data, input int lat);
    int c;
    int en_c;
    c = 0;
    while (!req_ready && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("ready_before_write", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = data;
    exp_q.push_back({rs, data});
    @(negedge clk);
    req_valid = 1'b0;
    req_rs    = 1'($urandom_range(0, 1));
    req_data  = 8'($urandom_range(0, 255));
    check("rs_next_cycle", 32'(LCD_RS), 32'(rs));
    check("data_next_cycle", 32'(LCD_DATA), 32'(data));
    check("ready_dropped", 32'(req_ready), 32'd0);
    c = 1;
    en_c = -1;
    while (!req_ready && c < 200) begin
      if (LCD_EN && en_c < 0) en_c = c;
      @(negedge clk);
      c++;
    end
    check("en_rise_offset", 32'(en_c), 32'(1 + SETUP));
    check("ready_latency", 32'(c), 32'(1 + lat));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_on"},    32'(LCD_ON),    32'd0);
    check({tag, "_rs"},    32'(LCD_RS),    32'd0);
    check({tag, "_en"},    32'(LCD_EN),    32'd0);
    check({tag, "_rw"},    32'(LCD_RW),    32'd0);
    check({tag, "_data"},  32'(LCD_DATA),  32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_done"},  32'(init_done), 32'd0);
  endtask

  initial begin
    logic       r_rs;
    logic [7:0] r_data;
    int         c;

    vecs[0] = '{1'b1, 8'h41, 16};
    vecs[1] = '{1'b0, 8'h01, 28};
    vecs[2] = '{1'b1, 8'h01, 16};
    vecs[3] = '{1'b0, 8'h02, 28};
    vecs[4] = '{1'b1, 8'h02, 16};
    vecs[5] = '{1'b0, 8'h38, 16};
    vecs[6] = '{1'b0, 8'h0C, 16};
    vecs[7] = '{1'b1, 8'hFF, 16};
    vecs[8] = '{1'b0, 8'h00, 16};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_rs    = 1'b0;
    req_data  = 8'h00;

    // Reset state and power-up init sequence.
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    push_init();
    run_init_check();

    // Table-driven writes, then a few random ones scored by a latency model.
    for (int i = 0; i < 9; i++) do_write(vecs[i].rs, vecs[i].data, vecs[i].lat);
    for (int i = 0; i < 4; i++) begin
      r_rs   = 1'($urandom_range(0, 1));
      r_data = (i < 2) ? 8'($urandom_range(1, 2)) : 8'($urandom_range(0, 255));
      do_write(r_rs, r_data, (!r_rs && (r_data == 8'h01 || r_data == 8'h02))
                             ? (SETUP + PULSE + HOLD + CLEARW)
                             : (SETUP + PULSE + HOLD + CMDW));
    end

    // Reset during EN of the second write of a pair.
    do_write(1'b1, 8'h41, 16);
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h42;
    exp_q.push_back({1'b1, 8'h42});
    @(negedge clk);
    req_valid = 1'b0;
    c = 0;
    while (!LCD_EN && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("second_write_en", 32'(LCD_EN), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midreset");
    @(negedge clk);
    reset = 1'b0;
    push_init();
    run_init_check();

    // Request held valid through init and across two writes.
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h55;
    push_init();
    exp_q.push_back({1'b1, 8'h55});
    run_init_check();
    @(negedge clk);
    check("held_first_ready", 32'(req_ready), 32'd0);
    check("held_first_data", 32'({LCD_RS, LCD_DATA}), 32'({1'b1, 8'h55}));
    req_data = 8'h66;
    exp_q.push_back({1'b1, 8'h66});
    c = 0;
    while (!req_ready && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("held_ready_back", 32'(c), 32'(SETUP + PULSE + HOLD + CMDW));
    @(negedge clk);
    req_valid = 1'b0;
    check("held_second_data", 32'({LCD_RS, LCD_DATA}), 32'({1'b1, 8'h66}));
    c = 0;
    while (!req_ready && c < 200) begin
      @(negedge clk);
      c++;
    end
    repeat (30) @(negedge clk);
    check("idle_ready", 32'(req_ready), 32'd1);
    check("done_sticky", 32'(init_done), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
